// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use stall and mult/div sequencing.
// Optional STALL_COUNT_EN adds a free-running count of PC-hold cycles.
module ex_hazard_ctrl #(
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IFtoID_Rs,
  input  logic [4:0] IFtoID_Rt,
  input  logic [4:0] IDtoEX_Rs,
  input  logic [4:0] IDtoEX_Rt,
  input  logic       IDtoEX_MemRead,
  input  logic [4:0] IDtoEX_RegDest,
  input  logic       EX_MulStart,
  input  logic       EXtoMEM_RegWrite,
  input  logic [4:0] EXtoMEM_RegDest,
  input  logic       WB_RegWrite,
  input  logic [4:0] WB_RegDest,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IDEX_Write,
  output logic       IDEX_Flush,
  output logic       EXMEM_Bubble,
  output logic       MulLaunch,
`ifdef STALL_COUNT_EN
  output logic       MulDone,
  output logic [31:0] StallCycles
`else
  output logic       MulDone
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       launch;
  logic       mul_stall;
  logic       mul_done;
  logic       load_use;

  // MEM beats WB so the youngest producer wins; $0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       mem_we,
                                         input logic [4:0] mem_rd,
                                         input logic       wb_we,
                                         input logic [4:0] wb_rd);
    if (mem_we && mem_rd != 5'd0 && mem_rd == src) return 2'b10;
    if (wb_we && wb_rd != 5'd0 && wb_rd == src)     return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    launch    = (state == IDLE) && EX_MulStart;
    mul_stall = (launch && MUL_LATENCY > 1) || (state == BUSY && cnt > 4'd1);
    mul_done  = (launch && MUL_LATENCY == 1) || (state == BUSY && cnt == 4'd1);
    load_use  = IDtoEX_MemRead && IDtoEX_RegDest != 5'd0 &&
                (IDtoEX_RegDest == IFtoID_Rs || IDtoEX_RegDest == IFtoID_Rt);
  end

  // A held mult owns ID/EX, so a pending load-use flush waits for MulDone.
  always_comb begin
    ForwardA     = 2'b00;
    ForwardB     = 2'b00;
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    IDEX_Flush   = 1'b0;
    EXMEM_Bubble = 1'b0;
    MulLaunch    = 1'b0;
    MulDone      = 1'b0;
    if (!reset) begin
      ForwardA     = fwd_sel(IDtoEX_Rs, EXtoMEM_RegWrite, EXtoMEM_RegDest, WB_RegWrite, WB_RegDest);
      ForwardB     = fwd_sel(IDtoEX_Rt, EXtoMEM_RegWrite, EXtoMEM_RegDest, WB_RegWrite, WB_RegDest);
      PCWrite      = !(mul_stall || load_use);
      IFID_Write   = !(mul_stall || load_use);
      IDEX_Write   = !mul_stall;
      IDEX_Flush   = load_use && !mul_stall;
      EXMEM_Bubble = mul_stall;
      MulLaunch    = launch;
      MulDone      = mul_done;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (EX_MulStart && MUL_LATENCY > 1) begin
            state <= BUSY;
            cnt   <= 4'(MUL_LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)         StallCycles <= 32'd0;
    else if (!PCWrite) StallCycles <= StallCycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed plus randomized bench for ex_hazard_ctrl, latency-4 and latency-1 instances
// checked against an occupancy-based reference model.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IFtoID_Rs, IFtoID_Rt, IDtoEX_Rs, IDtoEX_Rt, IDtoEX_RegDest;
  logic       IDtoEX_MemRead, EX_MulStart, EXtoMEM_RegWrite, WB_RegWrite;
  logic [4:0] EXtoMEM_RegDest, WB_RegDest;

  logic [1:0] fa4, fb4, fa1, fb1;
  logic       pcw4, ifw4, idw4, fl4, bub4, ml4, md4;
  logic       pcw1, ifw1, idw1, fl1, bub1, ml1, md1;
`ifdef STALL_COUNT_EN
  logic [31:0] sc4, sc1;
  int unsigned msc4, msc1;
  bit          sc_valid;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.MUL_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset),
    .IFtoID_Rs(IFtoID_Rs), .IFtoID_Rt(IFtoID_Rt),
    .IDtoEX_Rs(IDtoEX_Rs), .IDtoEX_Rt(IDtoEX_Rt),
    .IDtoEX_MemRead(IDtoEX_MemRead), .IDtoEX_RegDest(IDtoEX_RegDest),
    .EX_MulStart(EX_MulStart),
    .EXtoMEM_RegWrite(EXtoMEM_RegWrite), .EXtoMEM_RegDest(EXtoMEM_RegDest),
    .WB_RegWrite(WB_RegWrite), .WB_RegDest(WB_RegDest),
    .ForwardA(fa4), .ForwardB(fb4), .PCWrite(pcw4), .IFID_Write(ifw4),
    .IDEX_Write(idw4), .IDEX_Flush(fl4), .EXMEM_Bubble(bub4),
    .MulLaunch(ml4),
`ifdef STALL_COUNT_EN
    .MulDone(md4), .StallCycles(sc4)
`else
    .MulDone(md4)
`endif
  );

  ex_hazard_ctrl #(.MUL_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .IFtoID_Rs(IFtoID_Rs), .IFtoID_Rt(IFtoID_Rt),
    .IDtoEX_Rs(IDtoEX_Rs), .IDtoEX_Rt(IDtoEX_Rt),
    .IDtoEX_MemRead(IDtoEX_MemRead), .IDtoEX_RegDest(IDtoEX_RegDest),
    .EX_MulStart(EX_MulStart),
    .EXtoMEM_RegWrite(EXtoMEM_RegWrite), .EXtoMEM_RegDest(EXtoMEM_RegDest),
    .WB_RegWrite(WB_RegWrite), .WB_RegDest(WB_RegDest),
    .ForwardA(fa1), .ForwardB(fb1), .PCWrite(pcw1), .IFID_Write(ifw1),
    .IDEX_Write(idw1), .IDEX_Flush(fl1), .EXMEM_Bubble(bub1),
    .MulLaunch(ml1),
`ifdef STALL_COUNT_EN
    .MulDone(md1), .StallCycles(sc1)
`else
    .MulDone(md1)
`endif
  );

  typedef struct packed {
    logic [1:0] fa, fb;
    logic pcw, ifw, idw, fl, bub, ml, md;
  } exp_t;

  // Model state: whether a mult op occupies EX, and how many cycles it has been there.
  bit in_op4 = 0, in_op1 = 0;
  int age4 = 0, age1 = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (EXtoMEM_RegWrite && EXtoMEM_RegDest != 0 && EXtoMEM_RegDest == src) return 2'b10;
    if (WB_RegWrite && WB_RegDest != 0 && WB_RegDest == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t ref_out(input int lat, input bit in_op, input int age);
    exp_t e;
    bit start, stall, done, lu;
    e = '{fa: 2'b00, fb: 2'b00, pcw: 1, ifw: 1, idw: 1, fl: 0, bub: 0, ml: 0, md: 0};
    if (reset) return e;
    start = !in_op && EX_MulStart;
    stall = (start && lat > 1) || (in_op && age < lat - 1);
    done  = (start && lat == 1) || (in_op && age == lat - 1);
    lu = IDtoEX_MemRead && IDtoEX_RegDest != 0 &&
         (IDtoEX_RegDest == IFtoID_Rs || IDtoEX_RegDest == IFtoID_Rt);
    e.fa  = ref_fwd(IDtoEX_Rs);
    e.fb  = ref_fwd(IDtoEX_Rt);
    e.pcw = !(stall || lu);
    e.ifw = !(stall || lu);
    e.idw = !stall;
    e.fl  = lu && !stall;
    e.bub = stall;
    e.ml  = start;
    e.md  = done;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string name, input exp_t e, input exp_t o);
    chk({name, ".ForwardA"}, 32'(o.fa), 32'(e.fa));
    chk({name, ".ForwardB"}, 32'(o.fb), 32'(e.fb));
    chk({name, ".PCWrite"}, 32'(o.pcw), 32'(e.pcw));
    chk({name, ".IFID_Write"}, 32'(o.ifw), 32'(e.ifw));
    chk({name, ".IDEX_Write"}, 32'(o.idw), 32'(e.idw));
    chk({name, ".IDEX_Flush"}, 32'(o.fl), 32'(e.fl));
    chk({name, ".EXMEM_Bubble"}, 32'(o.bub), 32'(e.bub));
    chk({name, ".MulLaunch"}, 32'(o.ml), 32'(e.ml));
    chk({name, ".MulDone"}, 32'(o.md), 32'(e.md));
  endtask

  task automatic advance_model(input int lat, inout bit in_op, inout int age);
    bit start;
    start = !in_op && EX_MulStart;
    if (reset)                   begin in_op = 0; age = 0; end
    else if (start && lat > 1)   begin in_op = 1; age = 1; end
    else if (in_op) begin
      if (age == lat - 1) begin in_op = 0; age = 0; end
      else age++;
    end
  endtask

  // Inputs are already set after a negedge: compare, advance models, move to next negedge.
  task automatic tick();
    exp_t e4, e1;
    #1;
    e4 = ref_out(4, in_op4, age4);
    e1 = ref_out(1, in_op1, age1);
    chk_dut("L4", e4, {fa4, fb4, pcw4, ifw4, idw4, fl4, bub4, ml4, md4});
    chk_dut("L1", e1, {fa1, fb1, pcw1, ifw1, idw1, fl1, bub1, ml1, md1});
`ifdef STALL_COUNT_EN
    if (sc_valid) begin
      chk("L4.StallCycles", sc4, msc4);
      chk("L1.StallCycles", sc1, msc1);
    end
    if (reset) begin msc4 = 0; msc1 = 0; sc_valid = 1; end
    else begin msc4 += int'(!e4.pcw); msc1 += int'(!e1.pcw); end
`endif
    advance_model(4, in_op4, age4);
    advance_model(1, in_op1, age1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    IFtoID_Rs = 0; IFtoID_Rt = 0; IDtoEX_Rs = 0; IDtoEX_Rt = 0;
    IDtoEX_MemRead = 0; IDtoEX_RegDest = 0; EX_MulStart = 0;
    EXtoMEM_RegWrite = 0; EXtoMEM_RegDest = 0; WB_RegWrite = 0; WB_RegDest = 0;
  endtask

  initial begin
`ifdef STALL_COUNT_EN
    msc4 = 0; msc1 = 0; sc_valid = 0;
`endif
    clear_inputs();
    reset = 1;
    @(negedge clk);
    // Reset state: forced outputs even with hazards present on inputs.
    EX_MulStart = 1; IDtoEX_MemRead = 1; IDtoEX_RegDest = 3; IFtoID_Rs = 3;
    #1;
    chk("rst.PCWrite", 32'(pcw4), 1);
    chk("rst.MulLaunch", 32'(ml4), 0);
    tick();
    clear_inputs();
    tick();
    reset = 0;
    tick();

    // MEM priority over WB, then WB when MEM not writing.
    IDtoEX_Rs = 5; EXtoMEM_RegDest = 5; WB_RegDest = 5; EXtoMEM_RegWrite = 1; WB_RegWrite = 1;
    #1; chk("fwd.mem_prio", 32'(fa4), 32'h2);
    tick();
    EXtoMEM_RegWrite = 0;
    #1; chk("fwd.wb", 32'(fa4), 32'h1);
    tick();

    // $0 never forwarded.
    clear_inputs();
    EXtoMEM_RegWrite = 1; WB_RegWrite = 1;
    #1; chk("fwd.r0.A", 32'(fa4), 0); chk("fwd.r0.B", 32'(fb4), 0);
    tick();

    // Load-use on rt, then load in MEM forwards to B.
    clear_inputs();
    IDtoEX_MemRead = 1; IDtoEX_RegDest = 8; IFtoID_Rt = 8;
    #1; chk("lu.PCWrite", 32'(pcw4), 0); chk("lu.Flush", 32'(fl4), 1);
    tick();
    clear_inputs();
    EXtoMEM_RegWrite = 1; EXtoMEM_RegDest = 8; IDtoEX_Rt = 8;
    #1; chk("lu.fwdB", 32'(fb4), 32'h2); chk("lu.after.PCWrite", 32'(pcw4), 1);
    tick();

    // Mult with a concurrent load-use: flush held off until MulDone.
    clear_inputs();
    EX_MulStart = 1; IDtoEX_MemRead = 1; IDtoEX_RegDest = 9; IFtoID_Rs = 9;
    #1; chk("mul.launch", 32'(ml4), 1); chk("mul.L1.done", 32'(md1), 1);
    chk("mul.L1.nostall", 32'(idw1), 1);
    for (int i = 0; i < 3; i++) begin
      #1; chk("mul.stall.Flush", 32'(fl4), 0); chk("mul.stall.IDEX_Write", 32'(idw4), 0);
      tick();
    end
    #1; chk("mul.done", 32'(md4), 1); chk("mul.done.Flush", 32'(fl4), 1);
    chk("mul.done.Bubble", 32'(bub4), 0);
    tick();
    clear_inputs();
    tick();

    // Reset one cycle into a mult aborts it: no MulDone afterwards.
    EX_MulStart = 1;
    tick();
    reset = 1;
    tick();
    reset = 0; EX_MulStart = 0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("abort.noDone", 32'(md4), 0); chk("abort.PCWrite", 32'(pcw4), 1);
      tick();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reset            = ($urandom_range(0, 49) == 0);
      IFtoID_Rs        = 5'($urandom_range(0, 3));
      IFtoID_Rt        = 5'($urandom_range(0, 3));
      IDtoEX_Rs        = 5'($urandom_range(0, 3));
      IDtoEX_Rt        = 5'($urandom_range(0, 3));
      IDtoEX_MemRead   = ($urandom_range(0, 3) == 0);
      IDtoEX_RegDest   = 5'($urandom_range(0, 3));
      EX_MulStart      = ($urandom_range(0, 4) == 0);
      EXtoMEM_RegWrite = 1'($urandom_range(0, 1));
      EXtoMEM_RegDest  = 5'($urandom_range(0, 3));
      WB_RegWrite      = 1'($urandom_range(0, 1));
      WB_RegDest       = 5'($urandom_range(0, 3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
